// File: rtl/sap_pkg.sv
// Shared SAP-1 definitions: datapath widths, loader state encoding and
// the saturating word counter used by the programming-mode loader.
package sap_pkg;

    localparam int SAP_ADDR_W = 4;
    localparam int SAP_DATA_W = 8;
    localparam int LOAD_CNT_W = 5;

    localparam logic [LOAD_CNT_W-1:0] LOAD_CNT_MAX = '1;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        READY,
        ADDR,
        DATA,
        EXIT
    } loader_state_t;

    // Counter sticks at its maximum instead of wrapping back to zero
    function automatic logic [LOAD_CNT_W-1:0] sat_inc(input logic [LOAD_CNT_W-1:0] value);
        if (value == LOAD_CNT_MAX) begin
            return value;
        end
        return value + LOAD_CNT_W'(1);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Programming-mode sequencer: parks the controller, owns the bus and
// writes handshaked (address, data) words into RAM via MAR/RAM load cycles.
module prog_loader
    import sap_pkg::*;
#(
    parameter int ADDR_W = SAP_ADDR_W,
    parameter int DATA_W = SAP_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pr_mode,
    input  logic                    pr_valid,
    output logic                    pr_ready,
    input  logic [ADDR_W-1:0]       pr_address,
    input  logic [DATA_W-1:0]       pr_data,
    input  logic                    cpu_idle,
    output logic                    ctrl_hold,
    output logic                    bus_oe,
    output logic [DATA_W-1:0]       bus_drive,
    output logic                    mar_in,
    output logic                    ram_in,
    output logic                    cpu_restart,
    output logic [(2**ADDR_W)-1:0]  written_mask,
    output logic [LOAD_CNT_W-1:0]   load_count,
    output logic                    busy
);

    loader_state_t          state;
    loader_state_t          next_state;
    logic                   mode_q;
    logic                   mode_rise;
    logic                   accept;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      data_q;

    // mode_q clears on reset, so a request held through reset re-enters
    assign mode_rise = pr_mode && !mode_q;
    assign accept    = pr_valid && pr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A dropped request in DRAIN wins over a newly idle controller
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (mode_rise) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!pr_mode) begin
                    next_state = EXIT;
                end else if (cpu_idle) begin
                    next_state = READY;
                end
            end
            READY: begin
                if (accept) begin
                    next_state = ADDR;
                end else if (!pr_mode) begin
                    next_state = EXIT;
                end
            end
            ADDR: begin
                next_state = DATA;
            end
            DATA: begin
                if (pr_mode) begin
                    next_state = READY;
                end else begin
                    next_state = EXIT;
                end
            end
            EXIT: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_comb begin
        pr_ready    = 1'b0;
        ctrl_hold   = 1'b0;
        bus_oe      = 1'b0;
        bus_drive   = '0;
        mar_in      = 1'b0;
        ram_in      = 1'b0;
        cpu_restart = 1'b0;
        busy        = (state != IDLE);
        case (state)
            DRAIN: begin
                ctrl_hold = 1'b1;
            end
            READY: begin
                ctrl_hold = 1'b1;
                pr_ready  = 1'b1;
            end
            ADDR: begin
                ctrl_hold = 1'b1;
                bus_oe    = 1'b1;
                bus_drive = DATA_W'(addr_q);
                mar_in    = 1'b1;
            end
            DATA: begin
                ctrl_hold = 1'b1;
                bus_oe    = 1'b1;
                bus_drive = data_q;
                ram_in    = 1'b1;
            end
            EXIT: begin
                ctrl_hold   = 1'b1;
                cpu_restart = 1'b1;
            end
            default: begin
                busy = (state != IDLE);
            end
        endcase
    end

    // Session bookkeeping survives EXIT and is cleared only on the next entry
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            written_mask <= '0;
            load_count   <= '0;
        end else begin
            mode_q <= pr_mode;
            if (state == IDLE && mode_rise) begin
                written_mask <= '0;
                load_count   <= '0;
            end
            if (accept) begin
                addr_q <= pr_address;
                data_q <= pr_data;
            end
            if (state == DATA) begin
                written_mask[addr_q] <= 1'b1;
                load_count           <= sat_inc(load_count);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a bus/MAR/RAM model plus a
// scoreboard of accepted words checked against every RAM write.
module tb_prog_loader;
    import sap_pkg::*;

    logic                   clk;
    logic                   rst;
    logic                   pr_mode;
    logic                   pr_valid;
    logic                   pr_ready;
    logic [3:0]             pr_address;
    logic [7:0]             pr_data;
    logic                   cpu_idle;
    logic                   ctrl_hold;
    logic                   bus_oe;
    logic [7:0]             bus_drive;
    logic                   mar_in;
    logic                   ram_in;
    logic                   cpu_restart;
    logic [15:0]            written_mask;
    logic [LOAD_CNT_W-1:0]  load_count;
    logic                   busy;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [3:0]  addr;
        logic [7:0]  data;
        logic [15:0] exp_mask;
        logic [4:0]  exp_count;
    } vec_t;

    vec_t        vecs [5];
    wr_t         exp_q [$];
    logic [7:0]  ram_model [16];
    logic [7:0]  exp_ram [16];
    logic [3:0]  mar_model;
    logic        accepted;
    int          cycle_cnt;
    int          accept_cycle;
    int          prev_accept;
    int          n_checks;
    int          n_fail;

    prog_loader #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pr_mode      (pr_mode),
        .pr_valid     (pr_valid),
        .pr_ready     (pr_ready),
        .pr_address   (pr_address),
        .pr_data      (pr_data),
        .cpu_idle     (cpu_idle),
        .ctrl_hold    (ctrl_hold),
        .bus_oe       (bus_oe),
        .bus_drive    (bus_drive),
        .mar_in       (mar_in),
        .ram_in       (ram_in),
        .cpu_restart  (cpu_restart),
        .written_mask (written_mask),
        .load_count   (load_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Observe at the falling edge what the next rising edge will capture,
    // then step past that rising edge.
    task automatic cycle();
        logic [7:0] bus;
        wr_t        e;
        @(negedge clk);
        bus = bus_oe ? bus_drive : 8'h00;
        if (mar_in || ram_in) begin
            check_output("mar_in/ram_in exclusive", 32'(mar_in && ram_in), 0);
        end
        if (!rst && pr_valid && pr_ready) begin
            exp_q.push_back('{addr: pr_address, data: pr_data});
            accepted     = 1'b1;
            accept_cycle = cycle_cnt;
        end
        if (ram_in) begin
            if (exp_q.size() == 0) begin
                check_output("scoreboard underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_output("ram write addr", mar_model, e.addr);
                check_output("ram write data", bus, e.data);
            end
            ram_model[mar_model] = bus;
        end
        if (mar_in) begin
            mar_model = bus[3:0];
        end
        @(posedge clk);
        cycle_cnt++;
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, " pr_ready"}, pr_ready, 0);
        check_output({tag, " ctrl_hold"}, ctrl_hold, 0);
        check_output({tag, " bus_oe"}, bus_oe, 0);
        check_output({tag, " bus_drive"}, bus_drive, 0);
        check_output({tag, " mar_in"}, mar_in, 0);
        check_output({tag, " ram_in"}, ram_in, 0);
        check_output({tag, " cpu_restart"}, cpu_restart, 0);
        check_output({tag, " written_mask"}, written_mask, 0);
        check_output({tag, " load_count"}, load_count, 0);
        check_output({tag, " busy"}, busy, 0);
    endtask

    task automatic wait_accept(input string tag);
        accepted = 1'b0;
        for (int t = 0; t < 20 && !accepted; t++) begin
            cycle();
        end
        check_output({tag, " accept timeout"}, accepted, 1);
    endtask

    task automatic enter_session();
        pr_mode  = 1'b1;
        cpu_idle = 1'b1;
        cycle();
        check_output("entry ctrl_hold", ctrl_hold, 1);
        check_output("entry mask cleared", written_mask, 0);
        check_output("entry count cleared", load_count, 0);
        cycle();
        check_output("entry pr_ready", pr_ready, 1);
    endtask

    task automatic apply_stimulus(input logic [3:0] a, input logic [7:0] d);
        pr_address = a;
        pr_data    = d;
        pr_valid   = 1'b1;
        wait_accept("word");
        pr_valid = 1'b0;
        check_output("addr bus_oe", bus_oe, 1);
        check_output("addr mar_in", mar_in, 1);
        check_output("addr bus_drive", bus_drive, {4'h0, a});
        cycle();
        check_output("data ram_in", ram_in, 1);
        check_output("data mar_in", mar_in, 0);
        check_output("data bus_drive", bus_drive, d);
        cycle();
        if (pr_mode) begin
            check_output("ready after write", pr_ready, 1);
        end
    endtask

    task automatic exit_session();
        pr_mode = 1'b0;
        cycle();
        check_output("exit cpu_restart", cpu_restart, 1);
        check_output("exit ctrl_hold", ctrl_hold, 1);
        cycle();
        check_output("idle cpu_restart", cpu_restart, 0);
        check_output("idle ctrl_hold", ctrl_hold, 0);
        check_output("idle busy", busy, 0);
    endtask

    initial begin
        vecs[0] = '{4'h3, 8'h1E, 16'h0008, 5'd1};
        vecs[1] = '{4'h4, 8'h2F, 16'h0018, 5'd2};
        vecs[2] = '{4'hF, 8'h99, 16'h8018, 5'd3};
        vecs[3] = '{4'h0, 8'h01, 16'h8019, 5'd4};
        vecs[4] = '{4'h3, 8'h77, 16'h8019, 5'd5};

        n_checks   = 0;
        n_fail     = 0;
        cycle_cnt  = 0;
        mar_model  = '0;
        accepted   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ram_model[i] = 8'h00;
            exp_ram[i]   = 8'h00;
        end

        rst        = 1'b1;
        pr_mode    = 1'b0;
        pr_valid   = 1'b0;
        pr_address = '0;
        pr_data    = '0;
        cpu_idle   = 1'b0;
        @(posedge clk);
        #1;
        cycle();
        cycle();
        check_all_zero("reset");

        // Drain: controller busy for 5 cycles, offered word must be ignored
        rst      = 1'b0;
        pr_mode  = 1'b1;
        pr_valid = 1'b1;
        cycle();
        for (int i = 0; i < 5; i++) begin
            check_output("drain pr_ready", pr_ready, 0);
            check_output("drain ctrl_hold", ctrl_hold, 1);
            cycle();
        end
        check_output("drain busy", busy, 1);
        pr_valid = 1'b0;
        cpu_idle = 1'b1;
        cycle();
        check_output("drain release pr_ready", pr_ready, 1);

        // Basic load from the vector table
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].addr, vecs[i].data);
            check_output("table written_mask", written_mask, vecs[i].exp_mask);
            check_output("table load_count", load_count, vecs[i].exp_count);
            exp_ram[vecs[i].addr] = vecs[i].data;
        end
        exit_session();
        check_output("held mask", written_mask, 16'h8019);
        check_output("held count", load_count, 5);
        for (int i = 0; i < 5; i++) begin
            check_output("table ram", ram_model[vecs[i].addr], exp_ram[vecs[i].addr]);
        end

        // Back-to-back with pr_valid held high
        enter_session();
        pr_valid    = 1'b1;
        prev_accept = 0;
        for (int i = 0; i < 16; i++) begin
            pr_address = 4'(i);
            pr_data    = 8'(8'h40 + i);
            wait_accept("b2b");
            if (i > 0) begin
                check_output("b2b spacing", 32'(accept_cycle - prev_accept), 3);
            end
            prev_accept = accept_cycle;
        end
        pr_valid = 1'b0;
        cycle();
        cycle();
        check_output("b2b mask", written_mask, 16'hFFFF);
        check_output("b2b count", load_count, 16);
        exit_session();
        for (int i = 0; i < 16; i++) begin
            check_output("b2b ram", ram_model[i], 8'(8'h40 + i));
        end

        // Mode drops during ADDR: write completes, then EXIT
        enter_session();
        pr_address = 4'h7;
        pr_data    = 8'hA5;
        pr_valid   = 1'b1;
        wait_accept("midexit");
        pr_valid = 1'b0;
        pr_mode  = 1'b0;
        check_output("midexit mar_in", mar_in, 1);
        cycle();
        check_output("midexit ram_in", ram_in, 1);
        cycle();
        check_output("midexit cpu_restart", cpu_restart, 1);
        cycle();
        check_output("midexit busy", busy, 0);
        pr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_output("midexit no ready", pr_ready, 0);
            cycle();
        end
        pr_valid = 1'b0;
        check_output("midexit ram[7]", ram_model[7], 8'hA5);

        // Saturation and rewrite of one address
        enter_session();
        for (int i = 0; i < 40; i++) begin
            apply_stimulus(4'h2, 8'(i));
        end
        check_output("sat count", load_count, 31);
        check_output("sat mask", written_mask, 16'h0004);
        check_output("sat ram[2]", ram_model[2], 8'd39);

        // Reset in the DATA cycle: RAM still captures, no restart pulse
        pr_address = 4'h9;
        pr_data    = 8'h3C;
        pr_valid   = 1'b1;
        wait_accept("abort");
        pr_valid = 1'b0;
        cycle();
        check_output("abort in DATA", ram_in, 1);
        rst     = 1'b1;
        pr_mode = 1'b0;
        cycle();
        check_all_zero("abort");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_output("abort no restart", cpu_restart, 0);
            check_output("abort idle", busy, 0);
        end
        check_output("abort ram[9]", ram_model[9], 8'h3C);

        // Mode held high across reset release counts as a new request
        rst     = 1'b1;
        pr_mode = 1'b1;
        cycle();
        cycle();
        check_output("rst held busy", busy, 0);
        rst      = 1'b0;
        cpu_idle = 1'b0;
        cycle();
        check_output("rst release busy", busy, 1);
        check_output("rst release ctrl_hold", ctrl_hold, 1);
        pr_mode = 1'b0;
        cycle();
        check_output("drain exit cpu_restart", cpu_restart, 1);
        cycle();
        check_output("drain exit busy", busy, 0);

        check_output("scoreboard empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
